// File: rtl/alu_exec.sv
// Execute stage: one ALU op per start, single-cycle ops or an iterative shift-add MUL,
// returned as a one-cycle write-back pulse. Optional macro ALU_SAT_EN saturates ADD/SUB.
module alu_exec #(
  parameter int unsigned W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W:0]   s,
  input  logic [W:0]   t,
  input  logic [3:0]   rd_in,
  output logic         busy,
  output logic         wb_ena,
  output logic [3:0]   wb_rd,
  output logic [W:0]   wb_data,
  output logic         zero,
  output logic         carry
);

  localparam int unsigned DW = W + 1;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = $clog2(W + 2);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpShl = 3'd5;
  localparam logic [2:0] OpShr = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  logic [1:0]    state_q, state_d;
  logic [W:0]    mcand_q, mcand_d;
  logic [W:0]    mplier_q, mplier_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    wb_rd_q, wb_rd_d;
  logic [W:0]    wb_data_q, wb_data_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;

  logic [W:0]    alu_res;
  logic          alu_carry;
  logic [W+1:0]  sum;
  logic [W+1:0]  diff;
  logic [PW-1:0] addend;

  // Single-cycle result path; the MSB of diff is the unsigned borrow.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    sum       = {1'b0, s} + {1'b0, t};
    diff      = {1'b0, s} - {1'b0, t};
    case (op)
      OpAdd: begin
        alu_res   = sum[W:0];
        alu_carry = sum[W+1];
`ifdef ALU_SAT_EN
        if (sum[W+1]) alu_res = '1;
`endif
      end
      OpSub: begin
        alu_res   = diff[W:0];
        alu_carry = diff[W+1];
`ifdef ALU_SAT_EN
        if (diff[W+1]) alu_res = '0;
`endif
      end
      OpAnd: alu_res = s & t;
      OpOr:  alu_res = s | t;
      OpXor: alu_res = s ^ t;
      OpShl: begin
        alu_res   = {s[W-1:0], 1'b0};
        alu_carry = s[W];
      end
      OpShr: begin
        alu_res   = {1'b0, s[W:1]};
        alu_carry = s[0];
      end
      default: begin
        alu_res   = '0;
        alu_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    addend    = {{DW{1'b0}}, mcand_q} << cnt_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          wb_rd_d = rd_in;
          if (op == OpMul) begin
            mcand_d  = s;
            mplier_d = t;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = StMul;
          end else begin
            wb_data_d = alu_res;
            zero_d    = (alu_res == '0);
            carry_d   = alu_carry;
            state_d   = StWb;
          end
        end
      end
      StMul: begin
        // W+1 iterations, then one cycle to publish the low half and overflow flag.
        if (cnt_q == CW'(DW)) begin
          wb_data_d = acc_q[W:0];
          zero_d    = (acc_q[W:0] == '0);
          carry_d   = |acc_q[PW-1:DW];
          state_d   = StWb;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + addend;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
    end
  end

  // Register 0 is hardwired, so a write-back to it is suppressed.
  assign busy    = (state_q != StIdle);
  assign wb_ena  = (state_q == StWb) && (wb_rd_q != 4'd0);
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec (W=7): directed plan steps plus random ops against an arithmetic model.
module tb_alu_exec;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [7:0] s;
  logic [7:0] t;
  logic [3:0] rd_in;
  logic       busy;
  logic       wb_ena;
  logic [3:0] wb_rd;
  logic [7:0] wb_data;
  logic       zero;
  logic       carry;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected architectural state held between write-backs.
  logic [7:0] m_data;
  logic [3:0] m_rd;
  logic       m_zero;
  logic       m_carry;

  alu_exec #(.W(7)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .s       (s),
    .t       (t),
    .rd_in   (rd_in),
    .busy    (busy),
    .wb_ena  (wb_ena),
    .wb_rd   (wb_rd),
    .wb_data (wb_data),
    .zero    (zero),
    .carry   (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c);
    int unsigned ai;
    int unsigned bi;
    int unsigned full;
    ai = a;
    bi = b;
    r  = 8'h00;
    c  = 1'b0;
    case (o)
      3'd0: begin
        full = ai + bi;
        r = 8'(full % 256);
        c = (full > 255);
`ifdef ALU_SAT_EN
        if (c) r = 8'hFF;
`endif
      end
      3'd1: begin
        c = (ai < bi);
        r = 8'((ai + 256 - bi) % 256);
`ifdef ALU_SAT_EN
        if (c) r = 8'h00;
`endif
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin
        r = 8'((ai * 2) % 256);
        c = (ai >= 128);
      end
      3'd6: begin
        r = 8'(ai / 2);
        c = (ai % 2 == 1);
      end
      default: begin
        full = ai * bi;
        r = 8'(full % 256);
        c = (full > 255);
      end
    endcase
  endfunction

  task automatic check_wb(input logic exp_ena);
    check("wb_ena", wb_ena, exp_ena);
    check("wb_rd", wb_rd, m_rd);
    check("wb_data", wb_data, m_data);
    check("zero", zero, m_zero);
    check("carry", carry, m_carry);
    check("busy_wb", busy, 1'b1);
  endtask

  // Issues one op from IDLE and leaves the bench at the negedge of its write-back cycle.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] rdv);
    logic [7:0] r;
    logic       c;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_wb_ena", wb_ena, 1'b0);
    check("hold_data", wb_data, m_data);
    check("hold_zero", zero, m_zero);
    check("hold_carry", carry, m_carry);
    start = 1'b1;
    op    = o;
    s     = a;
    t     = b;
    rd_in = rdv;
    ref_alu(o, a, b, r, c);
    @(negedge clk);
    start = 1'b0;
    s     = 8'($urandom);
    t     = 8'($urandom);
    if (o == 3'd7) begin
      for (int k = 1; k <= 9; k++) begin
        check("mul_busy", busy, 1'b1);
        check("mul_no_wb", wb_ena, 1'b0);
        // A start while busy must be dropped.
        if (k == 3) begin
          start = 1'b1;
          op    = 3'd0;
          rd_in = 4'd5;
        end else begin
          start = 1'b0;
        end
        s = 8'($urandom);
        t = 8'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
    end
    m_data  = r;
    m_rd    = rdv;
    m_zero  = (r == 8'h00);
    m_carry = c;
    check_wb(rdv != 4'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    s     = 8'h00;
    t     = 8'h00;
    rd_in = 4'd0;
    m_data = 8'h00;
    m_rd = 4'd0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_wb_ena", wb_ena, 1'b0);
    check("rst_wb_rd", wb_rd, 4'd0);
    check("rst_wb_data", wb_data, 8'h00);
    check("rst_zero", zero, 1'b0);
    check("rst_carry", carry, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(3'd0, 8'hF0, 8'h20, 4'd3);
    run_op(3'd1, 8'h05, 8'h05, 4'd1);
    run_op(3'd1, 8'h03, 8'h05, 4'd2);
    run_op(3'd7, 8'd12, 8'd13, 4'd7);
    run_op(3'd7, 8'h20, 8'h10, 4'd4);
    run_op(3'd4, 8'h5A, 8'h0F, 4'd0);
    run_op(3'd5, 8'h81, 8'h00, 4'd6);
    run_op(3'd6, 8'h81, 8'h00, 4'd6);
    run_op(3'd2, 8'hCC, 8'hAA, 4'd9);
    run_op(3'd3, 8'h00, 8'h00, 4'd8);

    // Reset during the fourth MUL cycle aborts the op with no write-back.
    @(negedge clk);
    start = 1'b1;
    op    = 3'd7;
    s     = 8'hFF;
    t     = 8'hFF;
    rd_in = 4'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_wb_ena", wb_ena, 1'b0);
    check("mid_rst_wb_rd", wb_rd, 4'd0);
    check("mid_rst_wb_data", wb_data, 8'h00);
    check("mid_rst_zero", zero, 1'b0);
    check("mid_rst_carry", carry, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_data = 8'h00;
    m_rd = 4'd0;
    m_zero = 1'b0;
    m_carry = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("post_rst_wb_ena", wb_ena, 1'b0);
      check("post_rst_busy", busy, 1'b0);
    end
    run_op(3'd0, 8'h12, 8'h34, 4'd11);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(7, 0)), 8'($urandom), 8'($urandom), 4'($urandom));
    end

    @(negedge clk);
    check("final_busy", busy, 1'b0);
    check("final_wb_ena", wb_ena, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
